systolic_feed_ctrl: RTL and testbench
=====================================

# systolic_feed_ctrl

Tile-level sequencer that sits in front of the systolic skew/deskew movement stage. It streams a programmed number of row vectors from an upstream buffer into the movement stage, inserting bubbles when the source stalls. It then waits out the array fill/drain latency and reports completion to the kernel control logic. It owns the `i_data`/`i_valid` inputs of the movement stage; nothing else drives them.

## Interface
Parameters:
- `NUM_ROW`, 8: systolic array rows.
- `NUM_COL`, 8: systolic array columns; vector width in elements.
- `DATA_WIDTH`, 8: element width.
- `LEN_W`, 16: width of the tile-length field.
- `DRAIN_CYC`, `NUM_ROW+NUM_COL`: cycles waited after the last beat before `done`; must be ≥1.

Ports:
- `clk`  in  1: clock; all logic on the rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `start`  in  1: begin a tile; sampled only in IDLE.
- `abort`  in  1: synchronous abort of the tile; returns to IDLE.
- `k_len`  in  LEN_W: number of beats in the tile; latched on accepted `start`.
- `busy`  out  1: high in FEED and DRAIN.
- `done`  out  1: one-cycle pulse on tile completion.
- `src_data`  in  NUM_COL*DATA_WIDTH: upstream row vector.
- `src_valid`  in  1: upstream data valid.
- `src_ready`  out  1: controller accepts a beat this cycle.
- `mv_data`  out  NUM_COL*DATA_WIDTH: to movement stage `i_data`.
- `mv_valid`  out  NUM_COL: to movement stage `i_valid`.

## Operation
- States: IDLE, FEED, DRAIN, DONE.
- **IDLE**
  - With `start` and `k_len != 0`: latch `k_len` into `beats_left`, go to FEED.
  - With `start` and `k_len == 0`: go directly to DONE.
- **FEED**
  - `src_ready = (beats_left != 0)`, combinational from the state register and counter only; no path from `src_valid`.
  - A beat is accepted when `src_valid & src_ready`. Accepting a beat decrements `beats_left`.
  - When the last beat is accepted (`beats_left == 1`), load the drain counter with `DRAIN_CYC` and go to DRAIN.
- **DRAIN**: decrement the drain counter each cycle. When it reaches 1, go to DONE.
- **DONE**: assert `done` for exactly one cycle, then go to IDLE.
- Datapath:
  - `mv_data` and `mv_valid` are registered.
  - On an accepted beat: `mv_data <= src_data`, `mv_valid <= {NUM_COL{1'b1}}`.
  - Otherwise: `mv_data <= 0`, `mv_valid <= 0`. Bubbles always carry zero data.
  - `mv_valid` bits are always all-0 or all-1; the per-column skew is applied downstream by the movement stage.
- `abort` is honoured in any state other than IDLE.
  - Next state is IDLE; both counters are cleared; `mv_valid`/`mv_data` are 0 on the following cycle.
  - No `done` pulse is produced.
  - `abort` has priority over `start` and over the FEED→DRAIN and DRAIN→DONE transitions.
- `start` is ignored in FEED, DRAIN and DONE; `k_len` changes outside IDLE have no effect.
- Counters are LEN_W bits wide for beats and `$clog2(DRAIN_CYC+1)` bits wide for drain. Counters never wrap because decrement is gated by a non-zero value.

## Timing
- Reset values: state IDLE; `busy=0`, `done=0`, `src_ready=0`, `mv_valid=0`, `mv_data=0`; both counters 0.
- The start-to-ready path: `start` at cycle t → `busy=1` and `src_ready=1` at t+1.
- Beat latency: beat accepted at cycle t → `mv_valid=all-1` with that data at t+1.
- A tile with no stalls and `k_len=N` occupies FEED for N cycles.
  - DRAIN lasts `DRAIN_CYC` cycles.
  - `done` occurs `N+DRAIN_CYC+1` cycles after `start`.
  - Each stall cycle extends FEED by one cycle.
- `busy` falls in the same cycle that `done` rises. IDLE is entered the cycle after `done`.
- A new `start` is accepted on the first IDLE cycle after `done`. There is no back-to-back overlap between tiles.
- Reset asserted mid-tile clears all state immediately (asynchronous), regardless of state.

## Structure
- Shared package `systolic_ctrl_pkg` holds:
  - the state enum (IDLE, FEED, DRAIN, DONE);
  - the `LEN_W` default;
  - the helper constant for the drain-counter width.
- Single sub-module `systolic_down_counter`, instantiated twice (beat count and drain count). It provides a load/decrement counter with a zero flag and a synchronous clear.

## Test plan
- Reset then idle: hold `rst_n=0`, then release → every output is 0; `src_ready` stays 0 with `start=0`.
- Basic tile (defaults): `k_len=4`, `src_valid` held high, data 0x01..0x04 per byte → `mv_valid=0xFF` for 4 consecutive cycles starting at t+2 carrying 0x01..0x04; `done` at t+21; exactly 4 beats accepted.
- Source stall: `k_len=3`, `src_valid` pattern 1,0,0,1,1 → `mv_valid` pattern 0xFF,0,0,0xFF,0xFF; bubbles carry `mv_data=0`; `done` 2 cycles later than the no-stall case.
- Zero length: `k_len=0` with `start` → `done` at t+1, `busy` never high, `mv_valid` stays 0.
- Abort: `abort` pulsed in FEED after 2 of 5 beats, then again in DRAIN on a second tile → IDLE next cycle, no `done`, `src_ready=0`; a following `start` with `k_len=1` completes normally.
- Ignored start / async reset: `start` pulsed during DRAIN → no effect on timing. `rst_n` asserted mid-FEED → outputs 0 immediately, with no clock edge required.

Source files
------------

// File: rtl/systolic_ctrl_pkg.sv
// Shared types and constants for the systolic feed sequencer.
package systolic_ctrl_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StFeed,
        StDrain,
        StDone
    } state_e;

    localparam int unsigned LenWDefault = 16;

    // Width needed to hold a drain count of drain_cyc down to zero.
    function automatic int unsigned drain_cnt_w(input int unsigned drain_cyc);
        return $clog2(drain_cyc + 1);
    endfunction

endpackage

// File: rtl/systolic_down_counter.sv
// Loadable down counter with synchronous clear and zero flag; never wraps below zero.
module systolic_down_counter #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             dec,
    output logic [WIDTH-1:0] count,
    output logic             zero
);

    logic [WIDTH-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (load) begin
            count_d = load_val;
        end else if (dec && (count_q != '0)) begin
            count_d = count_q - WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
    assign zero  = (count_q == '0);

endmodule

// File: rtl/systolic_feed_ctrl.sv
// Streams a programmed number of row vectors into the skew/deskew stage, then waits out
// the array fill/drain latency and pulses done.
module systolic_feed_ctrl
    import systolic_ctrl_pkg::*;
#(
    parameter int unsigned NUM_ROW    = 8,
    parameter int unsigned NUM_COL    = 8,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned LEN_W      = LenWDefault,
    parameter int unsigned DRAIN_CYC  = NUM_ROW + NUM_COL
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic                          abort,
    input  logic [LEN_W-1:0]              k_len,
    output logic                          busy,
    output logic                          done,
    input  logic [NUM_COL*DATA_WIDTH-1:0] src_data,
    input  logic                          src_valid,
    output logic                          src_ready,
    output logic [NUM_COL*DATA_WIDTH-1:0] mv_data,
    output logic [NUM_COL-1:0]            mv_valid
);

    localparam int unsigned DrnW = drain_cnt_w(DRAIN_CYC);
    localparam int unsigned VecW = NUM_COL * DATA_WIDTH;

    state_e state_q, state_d;

    logic [LEN_W-1:0] beat_cnt;
    logic             beat_zero;
    logic [DrnW-1:0]  drain_cnt;
    logic             drain_zero;

    logic             abort_act;
    logic             accept;
    logic             last_beat;
    logic             tile_load;

    logic [VecW-1:0]    mv_data_q, mv_data_d;
    logic [NUM_COL-1:0] mv_valid_q, mv_valid_d;

    assign abort_act = abort && (state_q != StIdle);
    assign src_ready = (state_q == StFeed) && !beat_zero;
    assign accept    = src_ready && src_valid;
    assign last_beat = accept && (beat_cnt == LEN_W'(1));
    assign tile_load = (state_q == StIdle) && start && (k_len != '0);

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = (k_len != '0) ? StFeed : StDone;
                end
            end
            StFeed: begin
                if (last_beat) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                // An empty counter here would be a stuck state; leave rather than hang.
                if ((drain_cnt == DrnW'(1)) || drain_zero) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
        if (abort_act) begin
            state_d = StIdle;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    systolic_down_counter #(
        .WIDTH (LEN_W)
    ) u_beat_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (abort_act),
        .load     (tile_load),
        .load_val (k_len),
        .dec      (accept),
        .count    (beat_cnt),
        .zero     (beat_zero)
    );

    systolic_down_counter #(
        .WIDTH (DrnW)
    ) u_drain_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (abort_act),
        .load     (last_beat),
        .load_val (DrnW'(DRAIN_CYC)),
        .dec      (state_q == StDrain),
        .count    (drain_cnt),
        .zero     (drain_zero)
    );

    // Bubbles always carry zero data so downstream never sees stale rows.
    always_comb begin
        mv_data_d  = '0;
        mv_valid_d = '0;
        if (accept && !abort_act) begin
            mv_data_d  = src_data;
            mv_valid_d = '1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mv_data_q  <= '0;
            mv_valid_q <= '0;
        end else begin
            mv_data_q  <= mv_data_d;
            mv_valid_q <= mv_valid_d;
        end
    end

    assign mv_data  = mv_data_q;
    assign mv_valid = mv_valid_q;
    assign busy     = (state_q == StFeed) || (state_q == StDrain);
    assign done     = (state_q == StDone);

endmodule

// File: tb/tb_systolic_feed_ctrl.sv
// Self-checking bench for systolic_feed_ctrl: directed scenarios plus randomized tiles
// checked against a cycle-count model of the tile protocol.
module tb_systolic_feed_ctrl;

    localparam int D = 16;
    localparam int W = 64;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [15:0]   k_len = '0;
    logic          busy;
    logic          done;
    logic [W-1:0]  src_data = '0;
    logic          src_valid = 1'b0;
    logic          src_ready;
    logic [W-1:0]  mv_data;
    logic [7:0]    mv_valid;

    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    systolic_feed_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .abort     (abort),
        .k_len     (k_len),
        .busy      (busy),
        .done      (done),
        .src_data  (src_data),
        .src_valid (src_valid),
        .src_ready (src_ready),
        .mv_data   (mv_data),
        .mv_valid  (mv_valid)
    );

    task automatic test_reset();
        #1;
        n_checks++;
        if ({busy, done, src_ready} !== 3'b000 || mv_valid !== 8'h00 || mv_data !== '0) begin
            n_fail++;
            $display("FAIL reset_hold: busy=%b done=%b rdy=%b mvv=%h mvd=%h exp all 0",
                     busy, done, src_ready, mv_valid, mv_data);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            n_checks++;
            if ({busy, done, src_ready} !== 3'b000 || mv_valid !== 8'h00 || mv_data !== '0) begin
                n_fail++;
                $display("FAIL reset_idle cyc %0d: busy=%b done=%b rdy=%b mvv=%h exp all 0",
                         c, busy, done, src_ready, mv_valid);
            end
        end
    endtask

    task automatic test_basic();
        logic [W-1:0] exp_d;
        int acc;
        acc = 0;
        @(negedge clk);
        start = 1'b1;
        k_len = 16'd4;
        src_valid = 1'b1;
        src_data = '0;
        for (int c = 1; c <= 23; c++) begin
            @(negedge clk);
            exp_d = (c >= 2 && c <= 5) ? {8{8'(c - 1)}} : '0;
            n_checks++;
            if (mv_valid !== ((c >= 2 && c <= 5) ? 8'hFF : 8'h00) || mv_data !== exp_d) begin
                n_fail++;
                $display("FAIL basic_mv cyc %0d: got %h/%h exp data %h", c, mv_valid, mv_data,
                         exp_d);
            end
            n_checks++;
            if (done !== (c == 21)) begin
                n_fail++;
                $display("FAIL basic_done cyc %0d: got %b exp %b", c, done, (c == 21));
            end
            n_checks++;
            if (busy !== (c <= 20)) begin
                n_fail++;
                $display("FAIL basic_busy cyc %0d: got %b exp %b", c, busy, (c <= 20));
            end
            // Restart pulsed mid-drain with a different length must be ignored.
            start = (c == 10);
            k_len = (c == 10) ? 16'd3 : 16'd4;
            src_data = {8{8'(c)}};
            if (src_valid && src_ready) acc++;
        end
        src_valid = 1'b0;
        n_checks++;
        if (acc !== 4) begin
            n_fail++;
            $display("FAIL basic_beats: got %0d exp 4", acc);
        end
    endtask

    task automatic test_stall();
        bit pat [1:5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        bit exp_v;
        @(negedge clk);
        start = 1'b1;
        k_len = 16'd3;
        src_valid = 1'b0;
        for (int c = 1; c <= 24; c++) begin
            @(negedge clk);
            exp_v = (c >= 2 && c <= 6) ? pat[c - 1] : 1'b0;
            n_checks++;
            if (mv_valid !== (exp_v ? 8'hFF : 8'h00) ||
                mv_data !== (exp_v ? {8{8'(c - 1)}} : 64'h0)) begin
                n_fail++;
                $display("FAIL stall_mv cyc %0d: got %h/%h exp valid %b", c, mv_valid, mv_data,
                         exp_v);
            end
            n_checks++;
            if (done !== (c == 22) || busy !== (c <= 21)) begin
                n_fail++;
                $display("FAIL stall_ctl cyc %0d: done=%b busy=%b exp done %b busy %b", c, done,
                         busy, (c == 22), (c <= 21));
            end
            start = 1'b0;
            src_valid = (c <= 5) ? pat[c] : 1'b0;
            src_data = {8{8'(c)}};
        end
    endtask

    task automatic test_zero_len();
        @(negedge clk);
        start = 1'b1;
        k_len = 16'd0;
        src_valid = 1'b1;
        src_data = {8{8'h5A}};
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            start = 1'b0;
            n_checks++;
            if (done !== (c == 1) || busy !== 1'b0 || mv_valid !== 8'h00 || src_ready !== 1'b0)
            begin
                n_fail++;
                $display("FAIL zero_len cyc %0d: done=%b busy=%b mvv=%h rdy=%b exp done %b",
                         c, done, busy, mv_valid, src_ready, (c == 1));
            end
        end
        src_valid = 1'b0;
    endtask

    task automatic test_abort();
        // Tile 1: abort in FEED after two of five beats.
        @(negedge clk);
        start = 1'b1;
        k_len = 16'd5;
        src_valid = 1'b1;
        src_data = {8{8'h3C}};
        for (int c = 1; c <= 25; c++) begin
            @(negedge clk);
            start = 1'b0;
            abort = (c == 3);
            if (c == 4) begin
                n_checks++;
                if (busy !== 1'b0 || src_ready !== 1'b0 || mv_valid !== 8'h00 || mv_data !== '0)
                begin
                    n_fail++;
                    $display("FAIL abort_feed: busy=%b rdy=%b mvv=%h mvd=%h exp all 0", busy,
                             src_ready, mv_valid, mv_data);
                end
                src_valid = 1'b0;
            end
            if (c >= 4) begin
                n_checks++;
                if (done !== 1'b0 || busy !== 1'b0) begin
                    n_fail++;
                    $display("FAIL abort_feed_idle cyc %0d: done=%b busy=%b exp 0", c, done,
                             busy);
                end
            end
        end
        // Tile 2: abort in DRAIN.
        @(negedge clk);
        start = 1'b1;
        k_len = 16'd2;
        src_valid = 1'b1;
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (c == 3) src_valid = 1'b0;
            abort = (c == 10);
            if (c == 10) begin
                n_checks++;
                if (busy !== 1'b1) begin
                    n_fail++;
                    $display("FAIL abort_drain_pre: busy=%b exp 1", busy);
                end
            end
            if (c >= 11) begin
                n_checks++;
                if (done !== 1'b0 || busy !== 1'b0 || src_ready !== 1'b0 || mv_valid !== 8'h00)
                begin
                    n_fail++;
                    $display("FAIL abort_drain cyc %0d: done=%b busy=%b rdy=%b exp 0", c, done,
                             busy, src_ready);
                end
            end
        end
        // Tile 3: a normal single-beat tile afterwards.
        @(negedge clk);
        start = 1'b1;
        k_len = 16'd1;
        src_valid = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (c == 2) src_valid = 1'b0;
            n_checks++;
            if (done !== (c == 18) || busy !== (c <= 17)) begin
                n_fail++;
                $display("FAIL abort_recover cyc %0d: done=%b busy=%b exp %b %b", c, done, busy,
                         (c == 18), (c <= 17));
            end
        end
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        start = 1'b1;
        k_len = 16'd6;
        src_valid = 1'b1;
        src_data = {8{8'hA5}};
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (mv_valid !== 8'hFF || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL areset_pre: mvv=%h busy=%b exp ff 1", mv_valid, busy);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({busy, done, src_ready} !== 3'b000 || mv_valid !== 8'h00 || mv_data !== '0) begin
            n_fail++;
            $display("FAIL areset_now: busy=%b done=%b rdy=%b mvv=%h mvd=%h exp all 0", busy,
                     done, src_ready, mv_valid, mv_data);
        end
        @(negedge clk);
        rst_n = 1'b1;
        src_valid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_checks++;
            if (busy !== 1'b0 || src_ready !== 1'b0 || mv_valid !== 8'h00) begin
                n_fail++;
                $display("FAIL areset_idle cyc %0d: busy=%b rdy=%b mvv=%h exp 0", c, busy,
                         src_ready, mv_valid);
            end
        end
    endtask

    // Model: beats are accepted whenever the source is valid until n are taken; done
    // comes D+1 cycles after the last acceptance. Tiles are issued back to back.
    task automatic test_random_tiles();
        int n, acc, last, prob;
        bit feed, prev_acc, exp_busy, exp_done, got_done;
        logic [W-1:0] prev_data;
        for (int tile = 0; tile < 25; tile++) begin
            n = $urandom_range(1, 12);
            prob = $urandom_range(30, 100);
            @(negedge clk);
            n_checks++;
            if (busy !== 1'b0 || done !== 1'b0 || src_ready !== 1'b0 || mv_valid !== 8'h00) begin
                n_fail++;
                $display("FAIL rand_idle tile %0d: busy=%b done=%b rdy=%b mvv=%h exp 0", tile,
                         busy, done, src_ready, mv_valid);
            end
            start = 1'b1;
            k_len = 16'(n);
            src_valid = 1'($urandom_range(0, 1));
            src_data = {$urandom, $urandom};
            acc = 0;
            last = -1;
            prev_acc = 1'b0;
            prev_data = '0;
            got_done = 1'b0;
            for (int c = 1; c < 400 && !got_done; c++) begin
                @(negedge clk);
                feed = (acc < n);
                exp_busy = feed || (last >= 0 && c <= last + D);
                exp_done = (last >= 0 && c == last + D + 1);
                n_checks++;
                if (busy !== exp_busy || done !== exp_done || src_ready !== feed) begin
                    n_fail++;
                    $display("FAIL rand_ctl tile %0d cyc %0d: busy=%b done=%b rdy=%b exp %b %b %b",
                             tile, c, busy, done, src_ready, exp_busy, exp_done, feed);
                end
                n_checks++;
                if (mv_valid !== (prev_acc ? 8'hFF : 8'h00) ||
                    mv_data !== (prev_acc ? prev_data : 64'h0)) begin
                    n_fail++;
                    $display("FAIL rand_mv tile %0d cyc %0d: got %h/%h exp %b/%h", tile, c,
                             mv_valid, mv_data, prev_acc, prev_data);
                end
                if (exp_done) begin
                    got_done = 1'b1;
                    start = 1'b0;
                    src_valid = 1'b0;
                end else begin
                    start = ($urandom_range(0, 3) == 0);
                    k_len = 16'($urandom);
                    src_valid = ($urandom_range(1, 100) <= prob);
                    src_data = {$urandom, $urandom};
                    prev_acc = feed && src_valid;
                    prev_data = src_data;
                    if (prev_acc) begin
                        acc++;
                        if (acc == n) last = c;
                    end
                end
            end
            if (!got_done) begin
                n_fail++;
                $display("FAIL rand_timeout tile %0d: no done within budget, accepted %0d of %0d",
                         tile, acc, n);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_zero_len();
        test_abort();
        test_async_reset();
        test_random_tiles();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
